rc4_key_core: RTL and testbench

Parametrised RC4 key-test core for the key-search datapath. One instance takes a key of KEY_BYTES bytes, builds and shuffles its own 256-byte S state, and decrypts MSG_DEPTH bytes fetched from the encrypted-message ROM. It optionally checks each plaintext byte for lowercase/space and aborts on the first bad byte. Several instances sit side by side under the key-search controller, each with its own key slice and a ROM port.

---
 rtl/rc4_key_core.sv | 151 +++++++++++++++
 tb/tb_rc4_key_core.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rc4_key_core.sv
// RC4 key-test core: builds and shuffles S from a key, decrypts a ROM message and
// optionally rejects the key on the first plaintext byte outside lowercase/space.
module rc4_key_core #(
  parameter int unsigned KEY_BYTES   = 3,
  parameter int unsigned MSG_DEPTH   = 32,
  parameter int unsigned CHECK_ASCII = 1,
  parameter int unsigned AW          = $clog2(MSG_DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [8*KEY_BYTES-1:0] key,
  output logic [AW-1:0]          rom_addr,
  input  logic [7:0]             rom_q,
  output logic [AW-1:0]          out_addr,
  output logic [7:0]             out_data,
  output logic                   out_wren,
  output logic                   busy,
  output logic                   done,
  output logic                   key_valid
);

  localparam int unsigned   KW      = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam logic [AW-1:0] K_LAST  = AW'(MSG_DEPTH - 1);
  localparam logic [KW-1:0] KK_LAST = KW'(KEY_BYTES - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_INIT, S_K1, S_K2, S_P1, S_P2, S_P3, S_P4, S_DONE
  } state_t;

  state_t state, state_nx;

  logic [7:0]    s_mem [256];
  logic [7:0]    key_b [KEY_BYTES];
  logic [7:0]    i_q, j_q;
  logic [AW-1:0] k_q;
  logic [KW-1:0] kk_q;
  logic [AW-1:0] out_addr_q;
  logic [7:0]    out_data_q;

  logic [7:0] s_i, s_j, ks_byte, p_byte;
  logic       p_ok, k_last;

  assign s_i     = s_mem[i_q];
  assign s_j     = s_mem[j_q];
  assign ks_byte = s_mem[8'(s_i + s_j)];
  assign p_byte  = ks_byte ^ rom_q;
  assign p_ok    = (CHECK_ASCII == 0) || (p_byte == 8'd32) ||
                   ((p_byte >= 8'd97) && (p_byte <= 8'd122));
  assign k_last  = (k_q == K_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_INIT;
      S_INIT:  if (i_q == 8'hFF) state_nx = S_K1;
      S_K1:    state_nx = S_K2;
      S_K2:    state_nx = (i_q == 8'hFF) ? S_P1 : S_K1;
      S_P1:    state_nx = S_P2;
      S_P2:    state_nx = S_P3;
      S_P3:    state_nx = S_P4;
      S_P4:    state_nx = (!p_ok || k_last) ? S_DONE : S_P1;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // The plaintext byte only exists in P4 (rom_q lands there), so the strobe and
  // its payload are presented in P4 and held from registers between strobes.
  always_comb begin
    out_wren = 1'b0;
    out_addr = out_addr_q;
    out_data = out_data_q;
    if ((state == S_P4) && p_ok) begin
      out_wren = 1'b1;
      out_addr = k_q;
      out_data = p_byte;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      i_q        <= '0;
      j_q        <= '0;
      k_q        <= '0;
      kk_q       <= '0;
      rom_addr   <= '0;
      out_addr_q <= '0;
      out_data_q <= '0;
      key_valid  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      for (int n = 0; n < KEY_BYTES; n++) key_b[n] <= '0;
    end else begin
      busy <= (state_nx != S_IDLE);
      done <= (state_nx == S_DONE);
      case (state)
        S_IDLE: if (start) begin
          for (int n = 0; n < KEY_BYTES; n++) key_b[n] <= key[8*(KEY_BYTES-n)-1 -: 8];
          i_q       <= '0;
          j_q       <= '0;
          kk_q      <= '0;
          key_valid <= 1'b1;
        end
        S_INIT: i_q <= i_q + 8'd1;
        S_K1:   j_q <= j_q + s_i + key_b[kk_q];
        S_K2: begin
          i_q  <= i_q + 8'd1;
          kk_q <= (kk_q == KK_LAST) ? '0 : kk_q + KW'(1);
          if (i_q == 8'hFF) begin
            j_q <= '0;
            k_q <= '0;
          end
        end
        S_P1: i_q <= i_q + 8'd1;
        S_P2: begin
          j_q      <= j_q + s_i;
          rom_addr <= k_q;
        end
        S_P4: begin
          if (!p_ok) begin
            key_valid <= 1'b0;
          end else begin
            out_addr_q <= k_q;
            out_data_q <= p_byte;
            if (!k_last) k_q <= k_q + AW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // S array: identity fill in INIT, two-port swap in K2 and P3.
  always_ff @(posedge clk) begin
    case (state)
      S_INIT: s_mem[i_q] <= i_q;
      S_K2, S_P3: begin
        s_mem[i_q] <= s_j;
        s_mem[j_q] <= s_i;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rc4_key_core.sv
// Bench for rc4_key_core: known RC4 vectors on three parameter sets plus
// software-model runs, reset and protocol sequences on the default instance.
module tb_rc4_key_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [3:0] start_v;
  int         cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  // A: 3B key, 9 bytes, no check   D: same with check
  // B: 6B key, 14 bytes, no check  C: defaults (3B, 32 bytes, check)
  logic [23:0] a_key, d_key, c_key;
  logic [47:0] b_key;
  logic [3:0]  a_ra, d_ra, b_ra, a_oa, d_oa, b_oa;
  logic [4:0]  c_ra, c_oa;
  logic [7:0]  a_rq, d_rq, b_rq, c_rq, a_od, d_od, b_od, c_od;
  logic        a_we, d_we, b_we, c_we;
  logic        a_busy, d_busy, b_busy, c_busy;
  logic        a_done, d_done, b_done, c_done;
  logic        a_kv, d_kv, b_kv, c_kv;

  logic [7:0] rom_a [16];
  logic [7:0] rom_d [16];
  logic [7:0] rom_b [16];
  logic [7:0] rom_c [32];
  always @(posedge clk) begin
    a_rq <= rom_a[a_ra];
    d_rq <= rom_d[d_ra];
    b_rq <= rom_b[b_ra];
    c_rq <= rom_c[c_ra];
  end

  rc4_key_core #(.KEY_BYTES(3), .MSG_DEPTH(9), .CHECK_ASCII(0)) u_a (
    .clk(clk), .reset(reset), .start(start_v[0]), .key(a_key), .rom_addr(a_ra), .rom_q(a_rq),
    .out_addr(a_oa), .out_data(a_od), .out_wren(a_we), .busy(a_busy), .done(a_done), .key_valid(a_kv));
  rc4_key_core #(.KEY_BYTES(3), .MSG_DEPTH(9), .CHECK_ASCII(1)) u_d (
    .clk(clk), .reset(reset), .start(start_v[1]), .key(d_key), .rom_addr(d_ra), .rom_q(d_rq),
    .out_addr(d_oa), .out_data(d_od), .out_wren(d_we), .busy(d_busy), .done(d_done), .key_valid(d_kv));
  rc4_key_core #(.KEY_BYTES(6), .MSG_DEPTH(14), .CHECK_ASCII(0)) u_b (
    .clk(clk), .reset(reset), .start(start_v[2]), .key(b_key), .rom_addr(b_ra), .rom_q(b_rq),
    .out_addr(b_oa), .out_data(b_od), .out_wren(b_we), .busy(b_busy), .done(b_done), .key_valid(b_kv));
  rc4_key_core u_c (
    .clk(clk), .reset(reset), .start(start_v[3]), .key(c_key), .rom_addr(c_ra), .rom_q(c_rq),
    .out_addr(c_oa), .out_data(c_od), .out_wren(c_we), .busy(c_busy), .done(c_done), .key_valid(c_kv));

  logic [3:0] done_v, busy_v, kv_v;
  assign done_v = {c_done, b_done, d_done, a_done};
  assign busy_v = {c_busy, b_busy, d_busy, a_busy};
  assign kv_v   = {c_kv, b_kv, d_kv, a_kv};

  typedef logic [15:0] wr_t;
  wr_t oa[$], od[$], ob[$], oc[$], exp_q[$];
  int  ovl = 0;

  always @(negedge clk) begin
    if (a_we) oa.push_back({8'(a_oa), a_od});
    if (d_we) od.push_back({8'(d_oa), d_od});
    if (b_we) ob.push_back({8'(b_oa), b_od});
    if (c_we) oc.push_back({8'(c_oa), c_od});
    if ((a_we && a_done) || (d_we && d_done) || (b_we && b_done) || (c_we && c_done)) ovl++;
  end

  typedef struct packed {
    logic [1:0]   inst;
    logic [47:0]  key;
    logic [127:0] rom;
    logic [127:0] msg;
    logic [7:0]   nwr;
    logic [9:0]   lat;
    logic         kv;
  } vec_t;

  vec_t       vec [5];
  logic [7:0] ks    [32];
  logic [7:0] msg_c [32];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_obs();
    oa.delete(); od.delete(); ob.delete(); oc.delete(); exp_q.delete();
  endtask

  task automatic drain(input int inst, input string tag);
    wr_t got[$];
    wr_t e, g;
    case (inst)
      0:       got = oa;
      1:       got = od;
      2:       got = ob;
      default: got = oc;
    endcase
    chk({tag, " nwrites"}, got.size(), exp_q.size());
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got.size() > 0) ? got.pop_front() : 16'hxxxx;
      chk({tag, " write"}, g, e);
    end
  endtask

  task automatic go(input int inst, output int t0);
    @(negedge clk);
    start_v[inst] = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start_v[inst] = 1'b0;
  endtask

  // Optional poke on C: start pulse plus key change mid-run.
  task automatic wait_done(input int inst, input int t0, input bit poke, output int lat);
    lat = -1;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (poke && (cyc == t0 + 300)) begin
        start_v[3] = 1'b1;
        c_key = ~c_key;
      end
      if (poke && (cyc == t0 + 301)) start_v[3] = 1'b0;
      if (done_v[inst]) begin
        lat = cyc - t0;
        break;
      end
    end
  endtask

  task automatic rc4_gen(input logic [23:0] k);
    logic [7:0] s [256];
    logic [7:0] kb [3];
    logic [7:0] t, ii, jj;
    kb[0] = k[23:16]; kb[1] = k[15:8]; kb[2] = k[7:0];
    for (int n = 0; n < 256; n++) s[n] = 8'(n);
    jj = 8'd0;
    for (int n = 0; n < 256; n++) begin
      jj = jj + s[n] + kb[n % 3];
      t = s[n]; s[n] = s[jj]; s[jj] = t;
    end
    ii = 8'd0; jj = 8'd0;
    for (int n = 0; n < 32; n++) begin
      ii = ii + 8'd1;
      jj = jj + s[ii];
      t = s[ii]; s[ii] = s[jj]; s[jj] = t;
      ks[n] = s[8'(s[ii] + s[jj])];
    end
  endtask

  task automatic rand_msg();
    int r;
    for (int n = 0; n < 32; n++) begin
      r = $urandom_range(0, 26);
      msg_c[n] = (r == 26) ? 8'd32 : 8'(97 + r);
    end
  endtask

  // One run on C; corrupt >= 0 makes plaintext byte 'corrupt' equal 0x01.
  task automatic run_c(input logic [23:0] k, input int corrupt, input bit poke, input string tag);
    int t0, lat, nw;
    clear_obs();
    rc4_gen(k);
    for (int n = 0; n < 32; n++) rom_c[n] = ks[n] ^ msg_c[n];
    if (corrupt >= 0) rom_c[corrupt] = ks[corrupt] ^ 8'h01;
    nw = (corrupt >= 0) ? corrupt : 32;
    for (int n = 0; n < nw; n++) exp_q.push_back({8'(n), msg_c[n]});
    c_key = k;
    go(3, t0);
    wait_done(3, t0, poke, lat);
    chk({tag, " done latency"}, lat, (corrupt >= 0) ? 773 + 4 * corrupt : 897);
    chk({tag, " key_valid"}, c_kv, (corrupt >= 0) ? 0 : 1);
    chk({tag, " busy at done"}, c_busy, 1);
    @(negedge clk);
    chk({tag, " busy after done"}, c_busy, 0);
    drain(3, tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int         t0, t1, lat, cnt;
    logic [127:0] r, m;
    vec_t       v;

    vec[0] = '{inst: 2'd0, key: 48'h4B6579, rom: {72'hBBF316E8D940AF0AD3, 56'h0},
               msg: {"Plaintext", 56'h0}, nwr: 8'd9, lat: 10'd805, kv: 1'b1};
    vec[1] = '{inst: 2'd1, key: 48'h4B6579, rom: {72'hBBF316E8D940AF0AD3, 56'h0},
               msg: {"Plaintext", 56'h0}, nwr: 8'd0, lat: 10'd773, kv: 1'b0};
    vec[2] = '{inst: 2'd2, key: 48'h536563726574, rom: {112'h45A01F645FC35B383552544B9BF5, 16'h0},
               msg: {"Attack at dawn", 16'h0}, nwr: 8'd14, lat: 10'd825, kv: 1'b1};
    vec[3] = '{inst: 2'd1, key: 48'h4B6579, rom: {72'h9BF316E8D940AF0AD3, 56'h0},
               msg: {"plaintext", 56'h0}, nwr: 8'd9, lat: 10'd805, kv: 1'b1};
    vec[4] = '{inst: 2'd1, key: 48'h4B6579, rom: {72'h9BF316E8F940AF0AD3, 56'h0},
               msg: {"plaintext", 56'h0}, nwr: 8'd4, lat: 10'd789, kv: 1'b0};

    reset = 1'b0;
    start_v = '0;
    a_key = '0; d_key = '0; b_key = '0; c_key = '0;
    for (int n = 0; n < 16; n++) begin rom_a[n] = '0; rom_d[n] = '0; rom_b[n] = '0; end
    for (int n = 0; n < 32; n++) rom_c[n] = '0;
    repeat (3) @(negedge clk);
    chk("rst busy", busy_v, 4'h0);
    chk("rst done", done_v, 4'h0);
    chk("rst key_valid", kv_v, 4'h0);
    chk("rst outputs", {c_we, c_oa, c_od, c_ra}, 0);
    reset = 1'b1;

    for (int i = 0; i < 5; i++) begin
      v = vec[i];
      r = v.rom;
      m = v.msg;
      clear_obs();
      for (int n = 0; n < 16; n++) begin
        case (v.inst)
          2'd0:    rom_a[n] = r[127-8*n -: 8];
          2'd1:    rom_d[n] = r[127-8*n -: 8];
          default: rom_b[n] = r[127-8*n -: 8];
        endcase
      end
      for (int n = 0; n < int'(v.nwr); n++) exp_q.push_back({8'(n), m[127-8*n -: 8]});
      a_key = v.key[23:0];
      d_key = v.key[23:0];
      b_key = v.key;
      go(int'(v.inst), t0);
      wait_done(int'(v.inst), t0, 1'b0, lat);
      chk($sformatf("vec%0d done latency", i), lat, 32'(v.lat));
      chk($sformatf("vec%0d key_valid", i), kv_v[v.inst], v.kv);
      chk($sformatf("vec%0d busy at done", i), busy_v[v.inst], 1);
      @(negedge clk);
      chk($sformatf("vec%0d busy after done", i), busy_v[v.inst], 0);
      drain(int'(v.inst), $sformatf("vec%0d", i));
    end

    // Reset mid-KSA: outputs drop asynchronously and the run is lost.
    rand_msg();
    c_key = 24'($urandom);
    go(3, t0);
    repeat (398) @(negedge clk);
    chk("pre-reset busy", c_busy, 1);
    #1 reset = 1'b0;
    #1;
    chk("async reset busy", c_busy, 0);
    chk("async reset key_valid", c_kv, 0);
    chk("async reset outputs", {c_done, c_we, c_oa, c_od, c_ra}, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    cnt = 0;
    for (int n = 0; n < 1200; n++) begin
      @(negedge clk);
      if (c_done || c_busy) cnt++;
    end
    chk("no activity after reset", cnt, 0);
    run_c(24'h4B6579, -1, 1'b0, "post-reset Key");

    rand_msg();
    run_c(24'($urandom), -1, 1'b0, "random key");
    run_c(24'($urandom), 17, 1'b0, "corrupt k17");
    rand_msg();
    run_c(24'($urandom), -1, 1'b1, "mid-run start+key");

    // Start held high: back-to-back runs, each accepted only from IDLE.
    rand_msg();
    clear_obs();
    c_key = 24'($urandom);
    rc4_gen(c_key);
    for (int n = 0; n < 32; n++) rom_c[n] = ks[n] ^ msg_c[n];
    for (int rep = 0; rep < 2; rep++)
      for (int n = 0; n < 32; n++) exp_q.push_back({8'(n), msg_c[n]});
    @(negedge clk);
    start_v[3] = 1'b1;
    t0 = cyc;
    wait_done(3, t0, 1'b0, lat);
    chk("held run1 latency", lat, 897);
    @(negedge clk);
    chk("held idle cycle busy", c_busy, 0);
    t1 = cyc;
    wait_done(3, t1, 1'b0, lat);
    chk("held run2 latency", lat, 897);
    chk("held run2 busy at done", c_busy, 1);
    start_v[3] = 1'b0;
    cnt = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (c_busy) cnt++;
    end
    chk("held released idle", cnt, 0);
    drain(3, "held");

    chk("wren during done", ovl, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
